// File: rtl/lockin_demod_acc_if.sv
// Bundle between the lock-in sequencer, the reference table and the demodulator:
// frame setup, sample/reference stream and the X/Y frame results.
interface lockin_demod_acc_if #(
    parameter int DATA_W = 16,
    parameter int REF_W  = 32,
    parameter int ACC_W  = 64
);
    logic                     enable;
    logic        [31:0]       pts_x_ciclo;
    logic        [31:0]       ciclos_promediar;
    logic                     data_valid;
    logic signed [DATA_W-1:0] data_in;
    logic signed [REF_W-1:0]  ref_seno;
    logic signed [REF_W-1:0]  ref_cos;
    logic                     avanzar_en_tabla;
    logic                     ref_rst_n;
    logic signed [ACC_W-1:0]  x_out;
    logic signed [ACC_W-1:0]  y_out;
    logic                     data_out_valid;
    logic                     busy;

    modport master (
        output enable, pts_x_ciclo, ciclos_promediar,
        output data_valid, data_in, ref_seno, ref_cos,
        input  avanzar_en_tabla, ref_rst_n, x_out, y_out, data_out_valid, busy
    );

    modport slave (
        input  enable, pts_x_ciclo, ciclos_promediar,
        input  data_valid, data_in, ref_seno, ref_cos,
        output avanzar_en_tabla, ref_rst_n, x_out, y_out, data_out_valid, busy
    );
endinterface

// File: rtl/lockin_demod_acc.sv
// Lock-in coherent demodulator: multiplies samples by sin/cos references and
// accumulates X/Y over a frame of M*N samples, emitting one result per frame.
module lockin_demod_acc #(
    parameter int DATA_W = 16,
    parameter int REF_W  = 32,
    parameter int ACC_W  = 64
) (
    input  logic              clock,
    input  logic              reset_n,
    lockin_demod_acc_if.slave bus
);
    localparam int PROD_W = DATA_W + REF_W;

    typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, RUN = 2'd2} state_t;

    state_t                   state;
    logic        [31:0]       total;
    logic        [31:0]       sample_cnt;
    logic                     busy_q;
    logic                     ref_rst_n_q;
    logic                     accept;
    logic                     abort;
    logic                     last_hit;
    logic signed [PROD_W-1:0] prod_x;
    logic signed [PROD_W-1:0] prod_y;
    logic signed [PROD_W-1:0] px_p1;
    logic signed [PROD_W-1:0] py_p1;
    logic                     vld_p1;
    logic                     last_p1;
    logic signed [ACC_W-1:0]  acc_x_p2;
    logic signed [ACC_W-1:0]  acc_y_p2;
    logic signed [ACC_W-1:0]  x_out_q;
    logic signed [ACC_W-1:0]  y_out_q;
    logic                     vld_p2;

    // A zero M or N counts as one; the frame length wraps at 32 bits.
    function automatic logic [31:0] frame_len(input logic [31:0] m, input logic [31:0] n);
        logic [31:0] mm;
        logic [31:0] nn;
        mm = (m == 32'd0) ? 32'd1 : m;
        nn = (n == 32'd0) ? 32'd1 : n;
        return mm * nn;
    endfunction

    function automatic logic signed [ACC_W-1:0] sext(input logic signed [PROD_W-1:0] p);
        return {{(ACC_W-PROD_W){p[PROD_W-1]}}, p};
    endfunction

    assign accept   = (state == RUN) && bus.data_valid;
    assign abort    = (state == RUN) && !bus.enable;
    assign last_hit = (sample_cnt == total - 32'd1);
    assign prod_x   = PROD_W'(bus.data_in) * PROD_W'(bus.ref_seno);
    assign prod_y   = PROD_W'(bus.data_in) * PROD_W'(bus.ref_cos);

    assign bus.avanzar_en_tabla = accept;
    assign bus.ref_rst_n        = ref_rst_n_q;
    assign bus.busy             = busy_q;
    assign bus.x_out            = x_out_q;
    assign bus.y_out            = y_out_q;
    assign bus.data_out_valid   = vld_p2;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state       <= IDLE;
            total       <= 32'd0;
            sample_cnt  <= 32'd0;
            busy_q      <= 1'b0;
            ref_rst_n_q <= 1'b1;
        end else begin
            ref_rst_n_q <= 1'b1;
            case (state)
                IDLE: begin
                    if (bus.enable) begin
                        state       <= ARM;
                        ref_rst_n_q <= 1'b0;
                    end
                end
                ARM: begin
                    state      <= RUN;
                    busy_q     <= 1'b1;
                    total      <= frame_len(bus.pts_x_ciclo, bus.ciclos_promediar);
                    sample_cnt <= 32'd0;
                end
                RUN: begin
                    if (!bus.enable) begin
                        state      <= IDLE;
                        busy_q     <= 1'b0;
                        sample_cnt <= 32'd0;
                    end else if (accept) begin
                        sample_cnt <= last_hit ? 32'd0 : sample_cnt + 32'd1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            px_p1    <= '0;
            py_p1    <= '0;
            vld_p1   <= 1'b0;
            last_p1  <= 1'b0;
            acc_x_p2 <= '0;
            acc_y_p2 <= '0;
            x_out_q  <= '0;
            y_out_q  <= '0;
            vld_p2   <= 1'b0;
        end else begin
            // S1: register products; an abort discards whatever is in flight
            px_p1   <= prod_x;
            py_p1   <= prod_y;
            vld_p1  <= accept && !abort;
            last_p1 <= accept && !abort && last_hit;
            // S2: accumulate, closing the frame on the last product
            vld_p2  <= 1'b0;
            if (abort) begin
                acc_x_p2 <= '0;
                acc_y_p2 <= '0;
            end else if (vld_p1) begin
                if (last_p1) begin
                    x_out_q  <= acc_x_p2 + sext(px_p1);
                    y_out_q  <= acc_y_p2 + sext(py_p1);
                    acc_x_p2 <= '0;
                    acc_y_p2 <= '0;
                    vld_p2   <= 1'b1;
                end else begin
                    acc_x_p2 <= acc_x_p2 + sext(px_p1);
                    acc_y_p2 <= acc_y_p2 + sext(py_p1);
                end
            end
        end
    end
endmodule

// File: tb/tb_lockin_demod_acc.sv
// Directed bench for lockin_demod_acc: frame sums, back-to-back frames, gaps,
// abort, reset with a product in flight and the single-sample frame.
module tb_lockin_demod_acc;
    logic clock = 1'b0;
    logic reset_n;
    int   errors = 0;
    int   checks = 0;
    int   adv_cnt = 0;
    longint xq[$];
    longint yq[$];

    always #5 clock = ~clock;

    lockin_demod_acc_if #(.DATA_W(16), .REF_W(32), .ACC_W(64)) bus ();

    lockin_demod_acc #(.DATA_W(16), .REF_W(32), .ACC_W(64)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always @(negedge clock) begin
        if (bus.data_out_valid === 1'b1) begin
            xq.push_back(bus.x_out);
            yq.push_back(bus.y_out);
        end
        if (bus.avanzar_en_tabla === 1'b1) adv_cnt++;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic arm(input logic [31:0] m, input logic [31:0] n);
        bus.pts_x_ciclo      = m;
        bus.ciclos_promediar = n;
        bus.data_valid       = 1'b0;
        bus.enable           = 1'b1;
        tick();
        tick();
    endtask

    task automatic disarm();
        bus.enable     = 1'b0;
        bus.data_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic send(input logic signed [15:0] d);
        bus.data_in    = d;
        bus.data_valid = 1'b1;
        tick();
        bus.data_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_n        = 1'b0;
        bus.enable     = 1'b1;
        bus.data_valid = 1'b1;
        tick();
        checks++; if (bus.data_out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", bus.data_out_valid); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", bus.busy); end
        checks++; if (bus.ref_rst_n !== 1'b1) begin errors++; $display("FAIL rst_ref_rst_n got %b exp 1", bus.ref_rst_n); end
        checks++; if (bus.x_out !== 64'sd0) begin errors++; $display("FAIL rst_x got %0d exp 0", bus.x_out); end
        checks++; if (bus.y_out !== 64'sd0) begin errors++; $display("FAIL rst_y got %0d exp 0", bus.y_out); end
        checks++; if (bus.avanzar_en_tabla !== 1'b0) begin errors++; $display("FAIL rst_advance got %b exp 0", bus.avanzar_en_tabla); end
        reset_n        = 1'b1;
        bus.enable     = 1'b0;
        bus.data_valid = 1'b0;
        tick();
    endtask

    task automatic test_single_frame();
        int a0;
        xq.delete(); yq.delete();
        bus.ref_seno = 1000;
        bus.ref_cos  = -2;
        arm(4, 2);
        a0 = adv_cnt;
        for (int i = 0; i < 8; i++) send(100);
        checks++; if (bus.data_out_valid !== 1'b0) begin errors++; $display("FAIL t1_early_valid got %b exp 0", bus.data_out_valid); end
        tick();
        checks++; if (bus.data_out_valid !== 1'b1) begin errors++; $display("FAIL t1_valid_latency got %b exp 1", bus.data_out_valid); end
        checks++; if (bus.x_out !== 64'sd800000) begin errors++; $display("FAIL t1_x got %0d exp 800000", bus.x_out); end
        checks++; if (bus.y_out !== -64'sd1600) begin errors++; $display("FAIL t1_y got %0d exp -1600", bus.y_out); end
        tick();
        tick();
        checks++; if (xq.size() != 1) begin errors++; $display("FAIL t1_pulse_count got %0d exp 1", xq.size()); end
        checks++; if (adv_cnt - a0 != 8) begin errors++; $display("FAIL t1_advance_count got %0d exp 8", adv_cnt - a0); end
        disarm();
    endtask

    task automatic test_back_to_back();
        xq.delete(); yq.delete();
        arm(4, 2);
        for (int i = 0; i < 8; i++) send(100);
        for (int i = 0; i < 8; i++) send(1);
        tick(); tick(); tick();
        checks++;
        if (xq.size() != 2) begin
            errors++; $display("FAIL t2_pulse_count got %0d exp 2", xq.size());
        end else begin
            checks++; if (xq[0] != 800000) begin errors++; $display("FAIL t2_x0 got %0d exp 800000", xq[0]); end
            checks++; if (yq[0] != -1600) begin errors++; $display("FAIL t2_y0 got %0d exp -1600", yq[0]); end
            checks++; if (xq[1] != 8000) begin errors++; $display("FAIL t2_x1 got %0d exp 8000", xq[1]); end
            checks++; if (yq[1] != -16) begin errors++; $display("FAIL t2_y1 got %0d exp -16", yq[1]); end
        end
        disarm();
    endtask

    task automatic test_gaps();
        int a0;
        xq.delete(); yq.delete();
        arm(4, 2);
        a0 = adv_cnt;
        bus.data_in = 100;
        for (int i = 0; i < 22; i++) begin
            bus.data_valid = (i % 3 == 0);
            tick();
        end
        bus.data_valid = 1'b0;
        tick(); tick(); tick();
        checks++; if (adv_cnt - a0 != 8) begin errors++; $display("FAIL t3_advance_count got %0d exp 8", adv_cnt - a0); end
        checks++;
        if (xq.size() != 1) begin
            errors++; $display("FAIL t3_pulse_count got %0d exp 1", xq.size());
        end else begin
            checks++; if (xq[0] != 800000) begin errors++; $display("FAIL t3_x got %0d exp 800000", xq[0]); end
            checks++; if (yq[0] != -1600) begin errors++; $display("FAIL t3_y got %0d exp -1600", yq[0]); end
        end
        disarm();
    endtask

    task automatic test_abort();
        xq.delete(); yq.delete();
        bus.pts_x_ciclo      = 4;
        bus.ciclos_promediar = 2;
        bus.enable           = 1'b1;
        tick();
        checks++; if (bus.ref_rst_n !== 1'b0) begin errors++; $display("FAIL t4_arm_ref_rst_n got %b exp 0", bus.ref_rst_n); end
        tick();
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL t4_busy got %b exp 1", bus.busy); end
        for (int i = 0; i < 5; i++) send(100);
        bus.enable = 1'b0;
        tick();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL t4_abort_busy got %b exp 0", bus.busy); end
        tick(); tick();
        checks++; if (xq.size() != 0) begin errors++; $display("FAIL t4_partial_pulse got %0d exp 0", xq.size()); end
        checks++; if (bus.x_out !== 64'sd800000) begin errors++; $display("FAIL t4_x_hold got %0d exp 800000", bus.x_out); end
        bus.enable = 1'b1;
        tick();
        checks++; if (bus.ref_rst_n !== 1'b0) begin errors++; $display("FAIL t4_rearm_ref_rst_n got %b exp 0", bus.ref_rst_n); end
        tick();
        checks++; if (bus.ref_rst_n !== 1'b1) begin errors++; $display("FAIL t4_ref_rst_n_width got %b exp 1", bus.ref_rst_n); end
        for (int i = 0; i < 7; i++) send(100);
        tick(); tick(); tick();
        checks++; if (xq.size() != 0) begin errors++; $display("FAIL t4_early_frame got %0d exp 0", xq.size()); end
        send(100);
        tick(); tick();
        checks++;
        if (xq.size() != 1) begin
            errors++; $display("FAIL t4_pulse_count got %0d exp 1", xq.size());
        end else begin
            checks++; if (xq[0] != 800000) begin errors++; $display("FAIL t4_x got %0d exp 800000", xq[0]); end
        end
        disarm();
    endtask

    task automatic test_reset_inflight();
        xq.delete(); yq.delete();
        arm(4, 2);
        for (int i = 0; i < 8; i++) send(100);
        reset_n = 1'b0;
        tick();
        checks++; if (bus.data_out_valid !== 1'b0) begin errors++; $display("FAIL t5_valid got %b exp 0", bus.data_out_valid); end
        checks++; if (bus.x_out !== 64'sd0) begin errors++; $display("FAIL t5_x got %0d exp 0", bus.x_out); end
        checks++; if (bus.y_out !== 64'sd0) begin errors++; $display("FAIL t5_y got %0d exp 0", bus.y_out); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL t5_busy got %b exp 0", bus.busy); end
        reset_n    = 1'b1;
        bus.enable = 1'b0;
        tick(); tick(); tick();
        checks++; if (xq.size() != 0) begin errors++; $display("FAIL t5_pulse_count got %0d exp 0", xq.size()); end
    endtask

    task automatic test_total_one();
        xq.delete(); yq.delete();
        bus.ref_seno = 7;
        bus.ref_cos  = 5;
        arm(0, 0);
        send(-3);
        checks++; if (bus.data_out_valid !== 1'b0) begin errors++; $display("FAIL t6_early_valid got %b exp 0", bus.data_out_valid); end
        send(-3);
        checks++; if (bus.data_out_valid !== 1'b1) begin errors++; $display("FAIL t6_valid got %b exp 1", bus.data_out_valid); end
        checks++; if (bus.x_out !== -64'sd21) begin errors++; $display("FAIL t6_x got %0d exp -21", bus.x_out); end
        checks++; if (bus.y_out !== -64'sd15) begin errors++; $display("FAIL t6_y got %0d exp -15", bus.y_out); end
        send(-3);
        tick(); tick(); tick();
        checks++;
        if (xq.size() != 3) begin
            errors++; $display("FAIL t6_pulse_count got %0d exp 3", xq.size());
        end else begin
            checks++; if (xq[2] != -21) begin errors++; $display("FAIL t6_x_last got %0d exp -21", xq[2]); end
        end
        disarm();
    endtask

    initial begin
        reset_n              = 1'b0;
        bus.enable           = 1'b0;
        bus.pts_x_ciclo      = 32'd0;
        bus.ciclos_promediar = 32'd0;
        bus.data_valid       = 1'b0;
        bus.data_in          = '0;
        bus.ref_seno         = '0;
        bus.ref_cos          = '0;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_gaps();
        test_abort();
        test_reset_inflight();
        test_total_one();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
